// File: rtl/sprite_draw_if.sv
// Signal bundle between the CHIP-8 execute stage, main memory, the framebuffer RAM
// and the sprite rasteriser. The rasteriser uses the slave view; its environment uses master.
interface sprite_draw_if;
  // CPU side
  logic        start;
  logic [7:0]  x_in;
  logic [7:0]  y_in;
  logic [3:0]  n_in;
  logic [11:0] i_in;
  logic        busy;
  logic        done;
  logic        collision;
  // main memory (synchronous read)
  logic [11:0] mem_addr;
  logic [7:0]  mem_data;
  // framebuffer RAM (synchronous read port, write port)
  logic [9:0]  fb_read_address;
  logic [7:0]  fb_q;
  logic [9:0]  fb_write_address;
  logic [7:0]  fb_d;
  logic        fb_we;

  modport slave (
    input  start, x_in, y_in, n_in, i_in, mem_data, fb_q,
    output busy, done, collision, mem_addr,
           fb_read_address, fb_write_address, fb_d, fb_we
  );

  modport master (
    output start, x_in, y_in, n_in, i_in, mem_data, fb_q,
    input  busy, done, collision, mem_addr,
           fb_read_address, fb_write_address, fb_d, fb_we
  );
endinterface

// File: rtl/sprite_draw.sv
// CHIP-8 DXYN sprite rasteriser: fetches sprite rows from main memory and XORs them
// into the 128x64 1-bpp framebuffer with read-modify-write, reporting pixel collision.
module sprite_draw (
  input  logic        clk,
  input  logic        reset_n,
  sprite_draw_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_RDR,
    S_WRL,
    S_WRR,
    S_DONE
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic [6:0]  r_x;
  logic [5:0]  r_y;
  logic [11:0] r_i;
  logic [3:0]  r_rows;
  logic [3:0]  r_row;
  logic [15:0] r_pat;
  logic [7:0]  r_old_l;
  logic [7:0]  r_old_r;
  logic        r_collision;

  logic [2:0]  w_off;
  logic [3:0]  w_xb;
  logic [5:0]  w_fb_y;
  logic [9:0]  w_addr_l;
  logic [9:0]  w_addr_r;
  logic        w_right_en;
  logic        w_last_row;
  logic [6:0]  w_room;
  logic [3:0]  w_rows;
  logic        w_unused_bits;

  // Only the low 7 bits of Vx and low 6 bits of Vy address the screen.
  assign w_unused_bits = &{1'b0, bus.x_in[7], bus.y_in[7]};

  assign w_off      = r_x[2:0];
  assign w_xb       = r_x[6:3];
  assign w_fb_y     = r_y + {2'b00, r_row};
  assign w_addr_l   = {w_fb_y, w_xb};
  assign w_addr_r   = {w_fb_y, w_xb + 4'd1};
  assign w_right_en = (w_off != 3'd0) && (w_xb != 4'hF);
  assign w_last_row = ((r_row + 4'd1) == r_rows);

  // Rows below the bottom edge are clipped, so the row count is min(n, 64 - y).
  assign w_room = 7'd64 - {1'b0, bus.y_in[5:0]};
  assign w_rows = ({3'b000, bus.n_in} < w_room) ? bus.n_in : w_room[3:0];

  assign bus.collision = r_collision;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_x         <= '0;
      r_y         <= '0;
      r_i         <= '0;
      r_rows      <= '0;
      r_row       <= '0;
      r_pat       <= '0;
      r_old_l     <= '0;
      r_old_r     <= '0;
      r_collision <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_x         <= bus.x_in[6:0];
            r_y         <= bus.y_in[5:0];
            r_i         <= bus.i_in;
            r_rows      <= w_rows;
            r_row       <= '0;
            r_collision <= 1'b0;
          end
        end
        S_LOAD: begin
          r_pat <= {bus.mem_data, 8'h00} >> w_off;
        end
        S_RDR: begin
          r_old_l <= bus.fb_q;
        end
        S_WRL: begin
          r_old_r <= bus.fb_q;
          if ((r_old_l & r_pat[15:8]) != 8'h00) begin
            r_collision <= 1'b1;
          end
        end
        S_WRR: begin
          if (w_right_en && ((r_old_r & r_pat[7:0]) != 8'h00)) begin
            r_collision <= 1'b1;
          end
          r_row <= r_row + 4'd1;
        end
        default: begin
        end
      endcase
    end
  end

  // NOTE: every output of this block gets a default before the case, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    w_next               = r_state;
    bus.busy             = 1'b1;
    bus.done             = 1'b0;
    bus.mem_addr         = '0;
    bus.fb_read_address  = '0;
    bus.fb_write_address = '0;
    bus.fb_d             = '0;
    bus.fb_we            = 1'b0;

    case (r_state)
      S_IDLE: begin
        bus.busy = 1'b0;
        if (bus.start) begin
          w_next = (bus.n_in == 4'd0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: begin
        bus.mem_addr = r_i + {8'h00, r_row};
        w_next       = S_LOAD;
      end
      S_LOAD: begin
        bus.fb_read_address = w_addr_l;
        w_next              = S_RDR;
      end
      S_RDR: begin
        bus.fb_read_address = w_addr_r;
        w_next              = S_WRL;
      end
      S_WRL: begin
        // Read port is parked on the other byte so it never collides with the write.
        bus.fb_read_address  = w_addr_r;
        bus.fb_write_address = w_addr_l;
        bus.fb_d             = r_old_l ^ r_pat[15:8];
        bus.fb_we            = 1'b1;
        w_next               = S_WRR;
      end
      S_WRR: begin
        bus.fb_read_address = w_addr_l;
        if (w_right_en) begin
          bus.fb_write_address = w_addr_r;
          bus.fb_d             = r_old_r ^ r_pat[7:0];
          bus.fb_we            = 1'b1;
        end
        w_next = w_last_row ? S_DONE : S_FETCH;
      end
      S_DONE: begin
        bus.done = 1'b1;
        w_next   = S_IDLE;
      end
      default: begin
        bus.busy = 1'b0;
        w_next   = S_IDLE;
      end
    endcase
  end

endmodule

// File: doc/sprite_draw.md
# sprite_draw

XOR sprite rasteriser for the CHIP-8 core: executes DXYN by read-modify-writing the 1024 x 8-bit framebuffer RAM (128x64 pixels, 1 bpp). It fetches sprite bytes from main memory starting at I and XORs each row into the framebuffer. It reports pixel collision (VF) back to the CPU. It sits between the CPU execute stage and the framebuffer's read/write ports.

## Interface
Parameters:
- none; geometry is fixed at 128x64 pixels, 16 bytes per framebuffer row, address = y*16 + x/8, bit 7 = leftmost pixel.

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  draw request, sampled only in IDLE
- x_in  in  8  Vx; only [6:0] used (wraps mod 128)
- y_in  in  8  Vy; only [5:0] used (wraps mod 64)
- n_in  in  4  sprite height in rows, 0..15
- i_in  in  12  sprite base address (I register)
- busy  out  1  high while a draw is in progress
- done  out  1  one-cycle completion pulse
- collision  out  1  VF result; valid from done until next accepted start
- mem_addr  out  12  sprite byte address, (i + row) mod 4096
- mem_data  in  8  sprite byte, valid 1 cycle after mem_addr (synchronous read)
- fb_read_address  out  10  framebuffer read address
- fb_q  in  8  framebuffer read data, valid 1 cycle after fb_read_address
- fb_write_address  out  10  framebuffer write address
- fb_d  out  8  framebuffer write data
- fb_we  out  1  framebuffer write enable

## Operation
- Start accepted in IDLE: latch x = x_in[6:0], y = y_in[5:0], n, i; clear collision; row = 0.
- Visible rows v = min(n, 64 - y); rows at y+row >= 64 are clipped (no wrap).
- Per row, off = x[2:0], xb = x[6:3]; pattern {patL, patR} = {sprite, 8'h00} >> off.
- States, one cycle each:
  - FETCH: mem_addr = i + row.
  - LOAD: latch pattern from mem_data; fb_read_address = (y+row)*16 + xb.
  - RDR: latch fb_q as oldL; fb_read_address = left address + 1 (same row).
  - WRL: latch fb_q as oldR; write oldL ^ patL to the left address, fb_we = 1.
  - WRR: if off != 0 and xb != 15, write oldR ^ patR to the left address + 1, fb_we = 1; else no write (right byte clipped or empty). row++; go to FETCH if row < v, else DONE.
  - DONE: done = 1, busy = 1; next state IDLE.
- n = 0: IDLE -> DONE directly, no memory or framebuffer access, collision = 0.
- Collision sets if (oldL & patL) != 0 in WRL, or (oldR & patR) != 0 in a WRR that writes. It is sticky for the draw.
- start during busy is ignored (not queued).
- fb_we is 0 in every state other than WRL and qualifying WRR; fb_d and fb_write_address are don't-care when fb_we = 0.

## Timing
- Reset (async, reset_n low): state IDLE; busy, done, collision, fb_we = 0; all address/data outputs = 0. Takes effect immediately mid-draw: no further writes, rows already written stay modified.
- Start accepted in cycle 0; row r occupies cycles 5r+1..5r+5; done high in cycle 5v+1; busy high cycles 1..5v+1; IDLE in cycle 5v+2 (new start may be accepted there).
- n = 0: done and busy high in cycle 1 only.
- Framebuffer read and write are never issued to the same address in the same cycle.

## Test plan
- Cleared fb, x=0, y=0, n=1, mem[i]=0xF0 -> single write fb[0]=0xF0, no right write, collision=0, done in cycle 6.
- Repeat the same draw -> fb[0]=0x00, collision=1.
- Cleared fb, x=5, y=2, n=1, byte 0xFF -> fb[32]=0x07, fb[33]=0xF8, collision=0, done in cycle 6.
- x=125, y=62, n=4, bytes all 0xFF -> fb[1007]=0x07 and fb[1023]=0x07 only; right bytes and rows 64+ clipped; done in cycle 11.
- x_in=200, y_in=70, n=1, byte 0x81 -> wraps to x=72, y=6; fb[105]=0x81; mem_addr=i; i=0xFFF with n=2 fetches 0xFFF then 0x000.
- reset_n low during WRL of row 1 -> fb_we, busy, done drop to 0 at once, row 0 stays written; after release, start with n=0 -> done in cycle 1, collision=0.
